// File: rtl/lsu_pkg.sv
// lsu_pkg: definitions shared by the load/store alignment unit and its
// load-extension sub-module.
//   - RV32I funct3 width/sign codes for loads and stores
//   - FSM state encoding for the sub-word read-modify-write sequence
//   - byte-lane mask constants and a helper that places them on a word
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

    localparam logic [3:0] LANE_MASK_B = 4'b0001;
    localparam logic [3:0] LANE_MASK_H = 4'b0011;

    // Byte-lane write mask for a sub-word store. Halfwords always sit on
    // lane 0 or lane 2, selected by offset bit 1 only.
    function automatic logic [3:0] laneMask(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == F3_H) begin
            return LANE_MASK_H << {off[1], 1'b0};
        end
        return LANE_MASK_B << off;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: combinational load-data extraction and extension.
// Picks the addressed byte or halfword out of a little-endian memory word
// and sign- or zero-extends it; a word load passes the word through.
// Ports:
//   mem_rd  in  XLEN  raw memory word
//   addr_lo in  2     byte offset within the word
//   funct3  in  3     RV32I load width/sign code
//   rdata   out XLEN  extended load data (0 for undefined funct3)
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_rd,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] rdata
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Halfwords ignore offset bit 0; a misaligned halfword is either trapped
    // upstream or deliberately rounded down to its aligned lane pair.
    always_comb begin
        byteSel = mem_rd[{addr_lo, 3'b000} +: 8];
        halfSel = addr_lo[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (funct3)
            F3_B:    rdata = {{(XLEN-8){byteSel[7]}}, byteSel};
            F3_BU:   rdata = {{(XLEN-8){1'b0}}, byteSel};
            F3_H:    rdata = {{(XLEN-16){halfSel[15]}}, halfSel};
            F3_HU:   rdata = {{(XLEN-16){1'b0}}, halfSel};
            F3_W:    rdata = mem_rd;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the RV32I single-cycle
// datapath and a word-oriented data memory with combinational reads.
// Loads complete in the same cycle. SW writes in one cycle. SB/SH run a
// two-cycle read-modify-write: the first cycle stalls the core and captures
// the old word, the second writes the merged word back.
// Optional build macro: LSU_MISALIGN_TRAP_EN flags misaligned H/HU/W
// accesses, suppresses misaligned stores and zeroes misaligned loads.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req, we           access valid, 1 = store
//   funct3            width/sign code
//   addr, wdata       byte address, store data
//   rdata             extended load data
//   stall             hold the core while a sub-word store reads
//   misaligned        misaligned access flag (0 without the macro)
//   mem_we, mem_ad    memory write enable, word index
//   mem_wd, mem_rd    memory write data, memory read data
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int MEM_AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata,
    output logic              stall,
    output logic              misaligned,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_ad,
    output logic [XLEN-1:0]   mem_wd,
    input  logic [XLEN-1:0]   mem_rd
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   old_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic [15:0]       wd_q;
    logic [MEM_AW-1:0] ad_q;

    logic [MEM_AW-1:0] wordIdx;
    logic              misalign;
    logic              isSub;
    logic              isWord;
    logic              startRmw;
    logic [XLEN-1:0]   extData;
    logic [XLEN-1:0]   laneData;
    logic [XLEN-1:0]   mergeData;
    logic [3:0]        mask;

    assign wordIdx = MEM_AW'({2'b00, addr[XLEN-1:2]});
    assign isSub   = (funct3 == F3_B) || (funct3 == F3_H);
    assign isWord  = (funct3 == F3_W);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = req && ((((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0])
                              || (isWord && (addr[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif
    assign misaligned = misalign;

    assign startRmw = (state_q == ST_IDLE) && req && we && isSub && !misalign;

    lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
        .mem_rd  (mem_rd),
        .addr_lo (addr[1:0]),
        .funct3  (funct3),
        .rdata   (extData)
    );

    assign rdata = (req && !misalign) ? extData : '0;

    // Replace the latched target lane(s) of the captured old word with the
    // store data; the data is replicated so any lane can pick it up.
    always_comb begin
        mask      = laneMask(f3_q, off_q);
        laneData  = (f3_q == F3_H) ? {2{wd_q}} : {4{wd_q[7:0]}};
        mergeData = old_q;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                mergeData[8*k +: 8] = laneData[8*k +: 8];
            end
        end
    end

    // Next state and memory controls. MERGE ignores the core inputs and
    // always writes; reset overrides both handshake outputs so an
    // in-flight merge never reaches memory.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        mem_we  = 1'b0;
        mem_ad  = wordIdx;
        mem_wd  = wdata;
        case (state_q)
            ST_IDLE: begin
                if (startRmw) begin
                    stall   = 1'b1;
                    state_d = ST_MERGE;
                end else if (req && we && isWord && !misalign) begin
                    mem_we = 1'b1;
                end
            end
            ST_MERGE: begin
                mem_we  = 1'b1;
                mem_ad  = ad_q;
                mem_wd  = mergeData;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            stall  = 1'b0;
            mem_we = 1'b0;
        end
    end

    // State register plus request capture on the cycle a sub-word store
    // starts; the captured old word is what the merge is built from.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            old_q   <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            wd_q    <= '0;
            ad_q    <= '0;
        end else begin
            state_q <= state_d;
            if (startRmw) begin
                old_q <= mem_rd;
                off_q <= addr[1:0];
                f3_q  <= funct3;
                wd_q  <= wdata[15:0];
                ad_q  <= wordIdx;
            end
        end
    end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit between the RV32I single-cycle datapath and the word-oriented data memory.
- Converts byte addresses into word indices for the memory.
- Extracts and sign- or zero-extends LB/LH/LBU/LHU/LW load data.
- Performs SB/SH as a two-cycle read-modify-write, stalling the core for one cycle. SW completes in a single cycle.

Parameters:
- XLEN, 32, datapath and memory word width; only 32 is supported.
- MEM_AW, 32, width of mem_ad (word index).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  1  load or store access valid this cycle
- we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load data to writeback mux
- stall  out  1  hold PC and instruction; sub-word store in progress
- misaligned  out  1  misaligned access flag (see Optional Feature)
- mem_we  out  1  memory write enable
- mem_ad  out  MEM_AW  word index, equal to {2'b00, addr[31:2]}
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory combinational read data

Behaviour:
- Byte lanes are little-endian: lane k = mem_rd[8k+7:8k], k = addr[1:0].
- Loads are combinational, zero latency, single cycle:
  - B/BU select lane addr[1:0].
  - H/HU select halfword addr[1].
  - B/H sign-extend; BU/HU zero-extend.
- Loads with illegal funct3 (011, 110, 111) or with req=0: rdata=0.
- Stores with illegal funct3: no write.
- Store W in IDLE: mem_we=req&we, mem_wd=wdata, stall=0.
- State machine, state IDLE/MERGE, 1-bit:
  - IDLE, req&we&(funct3 B or H): stall=1, mem_we=0, mem_ad from addr.
  - That same posedge: latch mem_rd into old_q, latch addr[1:0], funct3, wdata[15:0] and mem_ad into the request registers; go to MERGE.
  - MERGE: mem_we=1, mem_ad from latched index, stall=0.
  - MERGE: mem_wd = old_q with the target lane(s) replaced by latched wdata[7:0] or wdata[15:0].
  - MERGE: core inputs are ignored.
  - MERGE always returns to IDLE on the next posedge.
- The core holds the instruction during stall. After MERGE, the core's PC advances, so no re-trigger occurs.
- Back-to-back sub-word stores: each costs 2 cycles; the IDLE cycle after MERGE may start a new RMW.
- Reset:
  - rst=1: state→IDLE, old_q and request registers→0.
  - While rst=1, mem_we=0 and stall=0 are forced combinationally.
  - Reset during MERGE aborts the write; the memory word is unchanged.
  - rdata follows the load path during reset, or is 0 when req=0.
- The core must not assert req with rst=1; the unit ignores it.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - misaligned = req & ((H/HU & addr[0]) | (W & addr[1:0]!=0)), combinational.
  - A misaligned store is suppressed: mem_we=0, no RMW entered.
  - A misaligned load returns rdata=0.
- Undefined:
  - misaligned tied 0.
  - W ignores addr[1:0]; H/HU ignore addr[0], using lane addr[1].

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding ST_IDLE, ST_MERGE.
  - Lane-select helper constants.
- One natural combinational sub-module: lsu_load_ext (mem_rd, addr[1:0], funct3 → rdata), reused by a future pipelined core.
- Merge logic and FSM stay in lsu_align.

Test Plan:
- Memory word 0x400 = 0xDEADBEEF; loads at addr 0x1000-0x1003:
  - LB 0x1001 → 0xFFFFFFBE
  - LBU 0x1003 → 0x000000DE
  - LH 0x1002 → 0xFFFFDEAD
  - LHU 0x1000 → 0x0000BEEF
  - LW 0x1000 → 0xDEADBEEF
  - All with mem_ad=0x400 and stall=0.
- SB addr 0x1001, wdata 0xAAAAAA12:
  - Cycle 0: stall=1, mem_we=0.
  - Cycle 1: mem_we=1, mem_ad=0x400, mem_wd=0xDEAD12EF, stall=0.
- SH 0x1002 with 0x5678, then SW 0x1004 with 0xCAFEBABE back-to-back:
  - First write mem_wd=0x5678BEEF.
  - SW writes on the next cycle with no stall.
  - 3 cycles total.
- SB issued, rst=1 asserted in the MERGE cycle → mem_we=0, word stays 0xDEADBEEF, state IDLE, stall=0 after reset.
- funct3=011 with req&we → mem_we=0 and stall=0 for all cycles.
- With LSU_MISALIGN_TRAP_EN:
  - LW 0x1002 → misaligned=1, rdata=0.
  - SH 0x1001 → misaligned=1, no stall, no write.
- Without LSU_MISALIGN_TRAP_EN: LW 0x1002 → misaligned=0, rdata=0xDEADBEEF.
